beat_mask_gen: RTL and testbench

- Splits a transfer length, in elements, into a stream of beats that are each Width lanes wide.
- Emits one lane-valid mask per beat: all lanes asserted on full beats, a partial tail mask on the last beat.
- Sits directly upstream of the tail-mask stage; it computes the last-lane index of each beat and feeds it to a heaviside instance.
- Typical consumer: strobe generation in DMA / stream front-ends.

---
 rtl/cf_math_pkg.sv | 15 +
 rtl/heaviside.sv | 23 ++
 rtl/beat_mask_gen.sv | 134 +++++++++++++
 tb/tb_beat_mask_gen.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/cf_math_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cf_math_pkg
// Description : Shared elaboration-time math helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package cf_math_pkg;

    // Bits needed to index num_idx entries; never less than one bit.
    function automatic int idx_width(input int num_idx);
        return (num_idx > 1) ? $clog2(num_idx) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/heaviside.sv
`default_nettype none
// ============================================================================
// Module      : heaviside
// Description : Thermometer decoder; sets lanes [0..i_idx] of the mask.
// Revision    : 1.0 - initial release
// ============================================================================
module heaviside
    import cf_math_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int IDX_WIDTH = idx_width(WIDTH)
) (
    input  logic [IDX_WIDTH-1:0] i_idx,
    output logic [WIDTH-1:0]     o_mask
);

    // Each lane is set when it lies at or below the highest valid index.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        assign o_mask[i] = (IDX_WIDTH'(i) <= i_idx);
    end

endmodule
`default_nettype wire

// File: rtl/beat_mask_gen.sv
`default_nettype none
// ============================================================================
// Module      : beat_mask_gen
// Description : Splits a transfer length into Width-lane beats and emits a
//               lane-valid mask, last-lane index, last flag and beat number
//               for every beat.
// Revision    : 1.0 - initial release
// ============================================================================
module beat_mask_gen
    import cf_math_pkg::*;
#(
    parameter int Width    = 32,
    parameter int LenWidth = 16,
    parameter int IdxWidth = idx_width(Width)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                len_valid_i,
    output logic                len_ready_o,
    input  logic [LenWidth-1:0] len_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [Width-1:0]    mask_o,
    output logic [IdxWidth-1:0] idx_o,
    output logic                last_o,
    output logic [LenWidth-1:0] beat_o
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [LenWidth-1:0] c_WIDTH_LEN  = LenWidth'(Width);
    localparam logic [IdxWidth-1:0] c_FULL_IDX   = IdxWidth'(Width - 1);

    // A length must always be able to hold at least one full beat count.
    if ((LenWidth < IdxWidth + 1) || (Width < 1)) begin : g_param_check
        $error("beat_mask_gen: LenWidth must be >= IdxWidth+1 and Width >= 1");
    end

    state_t                r_state;
    state_t                w_state_next;
    logic [LenWidth-1:0]   r_remaining;
    logic [LenWidth-1:0]   w_remaining_next;
    logic [LenWidth-1:0]   r_beat_cnt;
    logic [LenWidth-1:0]   w_beat_cnt_next;

    logic                  w_valid;
    logic                  w_full;
    logic [IdxWidth-1:0]   w_tail_idx;
    logic [IdxWidth-1:0]   w_idx;
    logic [Width-1:0]      w_hs_mask;

    // Beat decode: in BURST remaining is at least 1, so the tail index never
    // underflows; only the low IdxWidth bits of remaining-1 are ever used.
    assign w_valid    = (r_state == BURST);
    assign w_full     = (r_remaining > c_WIDTH_LEN);
    assign w_tail_idx = r_remaining[IdxWidth-1:0] - IdxWidth'(1);
    assign w_idx      = w_valid ? (w_full ? c_FULL_IDX : w_tail_idx) : '0;

    heaviside #(
        .WIDTH     (Width),
        .IDX_WIDTH (IdxWidth)
    ) u_heaviside (
        .i_idx  (w_idx),
        .o_mask (w_hs_mask)
    );

    assign len_ready_o = (r_state == IDLE);
    assign valid_o     = w_valid;
    assign idx_o       = w_idx;
    assign mask_o      = w_valid ? w_hs_mask : '0;
    assign last_o      = w_valid & ~w_full;
    assign beat_o      = w_valid ? r_beat_cnt : '0;

    // Next-state logic: accept lengths in IDLE, step through beats in BURST.
    always_comb begin
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        w_beat_cnt_next  = r_beat_cnt;
        case (r_state)
            IDLE: begin
                if (len_valid_i && (len_i != '0)) begin
                    w_state_next     = BURST;
                    w_remaining_next = len_i;
                    w_beat_cnt_next  = '0;
                end
            end
            BURST: begin
                if (ready_i) begin
                    if (!w_full) begin
                        w_state_next     = IDLE;
                        w_remaining_next = '0;
                    end else begin
                        w_remaining_next = r_remaining - c_WIDTH_LEN;
                        w_beat_cnt_next  = r_beat_cnt + LenWidth'(1);
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State registers; reset drops any transfer in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_beat_cnt  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_remaining <= w_remaining_next;
            r_beat_cnt  <= w_beat_cnt_next;
        end
    end

    // Lengths are never accepted while a burst is active.
    a_no_len_in_burst : assert property (
        @(posedge clk_i) disable iff (rst_i)
        (r_state == BURST) |-> !len_ready_o
    );

    // A stalled beat holds its contents and stays valid until taken.
    a_stable_stall : assert property (
        @(posedge clk_i) disable iff (rst_i)
        (valid_o && !ready_i) |=> (valid_o && $stable(mask_o) && $stable(idx_o)
                                   && $stable(last_o) && $stable(beat_o))
    );

endmodule
`default_nettype wire

// File: tb/tb_beat_mask_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_beat_mask_gen
// Description : Self-checking bench for beat_mask_gen (Width=8, LenWidth=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_beat_mask_gen;

    localparam int c_W  = 8;
    localparam int c_LW = 16;
    localparam int c_IW = 3;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            len_valid_i = 1'b0;
    logic            len_ready_o;
    logic [c_LW-1:0] len_i = '0;
    logic            valid_o;
    logic            ready_i = 1'b0;
    logic [c_W-1:0]  mask_o;
    logic [c_IW-1:0] idx_o;
    logic            last_o;
    logic [c_LW-1:0] beat_o;

    int n_tests = 0;
    int n_fail  = 0;

    beat_mask_gen #(
        .Width    (c_W),
        .LenWidth (c_LW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .len_valid_i (len_valid_i),
        .len_ready_o (len_ready_o),
        .len_i       (len_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .mask_o      (mask_o),
        .idx_o       (idx_o),
        .last_o      (last_o),
        .beat_o      (beat_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock and settle away from the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: a beat with r elements still outstanding carries min(r,W) lanes.
    function automatic logic [31:0] ref_mask(input int r);
        int lanes;
        lanes = (r >= c_W) ? c_W : r;
        return (32'd1 << lanes) - 32'd1;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, valid_o, 0);
        chk({tag, "_mask"}, mask_o, 0);
        chk({tag, "_idx"}, idx_o, 0);
        chk({tag, "_last"}, last_o, 0);
        chk({tag, "_beat"}, beat_o, 0);
        chk({tag, "_lenrdy"}, len_ready_o, 1);
    endtask

    task automatic chk_beat(input int len, input int k);
        int r;
        r = len - c_W * k;
        chk("beat_valid", valid_o, 1);
        chk("beat_lenrdy", len_ready_o, 0);
        chk("beat_mask", mask_o, ref_mask(r));
        chk("beat_idx", idx_o, (r >= c_W) ? c_W - 1 : r - 1);
        chk("beat_last", last_o, (r <= c_W) ? 1 : 0);
        chk("beat_num", beat_o, k);
    endtask

    // mode 0: always ready; 1: random backpressure; 2: stall first beat 3 cycles
    task automatic run_xfer(input int len, input int mode);
        int nb;
        int k;
        int guard;
        int stall;
        guard = 0;
        while (!len_ready_o && guard < 20) begin
            step();
            guard++;
        end
        chk("pre_lenrdy", len_ready_o, 1);
        len_valid_i = 1'b1;
        len_i       = len[c_LW-1:0];
        step();
        len_valid_i = 1'b0;
        len_i       = 16'($urandom);
        nb    = (len + c_W - 1) / c_W;
        k     = 0;
        guard = 0;
        stall = (mode == 2) ? 3 : 0;
        while (k < nb && guard < 1000) begin
            chk_beat(len, k);
            if (stall > 0) begin
                ready_i = 1'b0;
                stall--;
            end else if (mode == 1) begin
                ready_i = ($urandom_range(0, 9) < 7);
            end else begin
                ready_i = 1'b1;
            end
            step();
            if (ready_i) k++;
            guard++;
        end
        chk("xfer_timeout", (guard < 1000) ? 1 : 0, 1);
        chk_idle("post");
    endtask

    initial begin
        // Reset
        step();
        step();
        rst_i = 1'b0;
        chk_idle("reset");

        // Directed cases
        run_xfer(5, 0);
        run_xfer(20, 0);
        run_xfer(16, 0);
        run_xfer(0, 0);
        step();
        chk_idle("len0_again");
        run_xfer(10, 2);
        run_xfer(8, 0);
        run_xfer(1, 0);

        // Reset mid-burst on beat 2 of a 40-element transfer
        len_valid_i = 1'b1;
        len_i       = 16'd40;
        ready_i     = 1'b1;
        step();
        len_valid_i = 1'b0;
        chk_beat(40, 0);
        step();
        chk_beat(40, 1);
        step();
        chk_beat(40, 2);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk_idle("midrst");
        step();
        chk_idle("midrst_hold");
        run_xfer(3, 0);

        // Randomized transfers with random backpressure
        for (int t = 0; t < 25; t++) begin
            run_xfer($urandom_range(0, 70), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
